// File: rtl/rv_pkg.sv
// Shared RV32I decode constants used by the hazard/forwarding unit, the
// ALU decoder and the control unit.
package rv_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int FWD_REGFILE = 0;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: which register operands an instruction
// reads, whether it writes rd, and whether its result comes from memory.
module opcode_class
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_load
);

    // Decode opcode into operand-usage flags; unknown opcodes use and write nothing
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OPC_R: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_IMM, OPC_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-boundary hazard controller: tracks in-flight writers in the
// downstream stages, selects forwarding sources per operand, stalls on
// load-use, kills the decode slot after a redirect, and counts both events.
module hazard_forward_unit
    import rv_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_STAGES   = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             d_valid,
    input  logic [6:0]                       d_opcode,
    input  logic [REG_AW-1:0]                d_rs1,
    input  logic [REG_AW-1:0]                d_rs2,
    input  logic [REG_AW-1:0]                d_rd,
    input  logic                             redirect,
    output logic                             stall,
    output logic                             flush,
    output logic [$clog2(FWD_STAGES+1)-1:0]  fwd_sel_a,
    output logic [$clog2(FWD_STAGES+1)-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]                 stall_count,
    output logic [CNT_W-1:0]                 flush_count
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } stage_t;

    // Entry k describes the instruction currently in downstream stage k
    stage_t            stage_q [1:FWD_STAGES];
    stage_t            stage1_d;
    logic [FC_W-1:0]   flush_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_evt_q;

    logic              uses_rs1, uses_rs2, writes_rd, is_load;
    logic [SEL_W-1:0]  sel_a_raw, sel_b_raw;
    logic              ld_a_raw, ld_b_raw;
    logic              use_a, use_b;
    logic              lu_a, lu_b;

    opcode_class u_opcode_class (
        .opcode    (d_opcode),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load)
    );

    // Youngest-writer search: scan oldest to youngest so the smallest k wins
    always_comb begin
        sel_a_raw = '0;
        sel_b_raw = '0;
        ld_a_raw  = 1'b0;
        ld_b_raw  = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (stage_q[k].valid && stage_q[k].wr && (stage_q[k].rd == d_rs1)) begin
                sel_a_raw = SEL_W'(k);
                ld_a_raw  = stage_q[k].is_load && (k <= LOAD_LAT);
            end
            if (stage_q[k].valid && stage_q[k].wr && (stage_q[k].rd == d_rs2)) begin
                sel_b_raw = SEL_W'(k);
                ld_b_raw  = stage_q[k].is_load && (k <= LOAD_LAT);
            end
        end
    end

    // x0 is hard-wired zero, so a source of x0 never takes a forwarded value
    assign use_a = uses_rs1 && (d_rs1 != '0) && (sel_a_raw != '0);
    assign use_b = uses_rs2 && (d_rs2 != '0) && (sel_b_raw != '0);
    assign lu_a  = use_a && ld_a_raw;
    assign lu_b  = use_b && ld_b_raw;

    // A killed decode slot never stalls; reset forces all control outputs low
    assign flush     = !rst && (redirect || (flush_cnt_q != '0));
    assign stall     = !rst && d_valid && (lu_a || lu_b) && !flush;
    assign fwd_sel_a = (!rst && use_a && !lu_a) ? sel_a_raw : SEL_W'(FWD_REGFILE);
    assign fwd_sel_b = (!rst && use_b && !lu_b) ? sel_b_raw : SEL_W'(FWD_REGFILE);

    // Next stage-1 entry: a bubble unless a live, unstalled, unflushed instruction issues
    always_comb begin
        stage1_d = '0;
        if (d_valid && !stall && !flush) begin
            stage1_d.valid   = 1'b1;
            stage1_d.wr      = writes_rd && (d_rd != '0);
            stage1_d.rd      = d_rd;
            stage1_d.is_load = is_load;
        end
    end

    // Advance the writer-tracking shift register one stage per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the stage entries are control state, not data storage, so every one is reset to invalid.
            for (int k = 1; k <= FWD_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every entry shift from its pre-edge neighbour.
            stage_q[1] <= stage1_d;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Flush window: a redirect (re)loads the countdown, otherwise it drains to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (redirect) begin
            flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
        end
    end

    // Saturating performance counters for stall cycles and redirect events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect && (flush_evt_q != '1)) begin
                flush_evt_q <= flush_evt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_evt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: a queue-based reference model
// checked every negedge, plus directed scenarios with literal expectations.
module tb_hazard_forward_unit;

    localparam int N    = 2;   // FWD_STAGES
    localparam int LL   = 1;   // LOAD_LAT
    localparam int FC   = 2;   // FLUSH_CYCLES
    localparam int CW   = 4;   // CNT_W
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] LD = 7'b0000011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_valid = 1'b0;
    logic [6:0] d_opcode = '0;
    logic [4:0] d_rs1 = '0;
    logic [4:0] d_rs2 = '0;
    logic [4:0] d_rd = '0;
    logic       redirect = 1'b0;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    hazard_forward_unit #(
        .REG_AW       (5),
        .FWD_STAGES   (N),
        .LOAD_LAT     (LL),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_valid     (d_valid),
        .d_opcode    (d_opcode),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_rd        (d_rd),
        .redirect    (redirect),
        .stall       (stall),
        .flush       (flush),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit       wr;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    ent_t pipe[$];   // pipe[0] is stage 1 (youngest)
    int   m_fc;      // remaining extra flush cycles
    int   m_sc;      // expected stall_count
    int   m_fe;      // expected flush_count

    function automatic void classify(input logic [6:0] op, output bit u1, output bit u2,
                                     output bit w, output bit ld);
        u1 = 0; u2 = 0; w = 0; ld = 0;
        case (op)
            7'b0110011: begin u1 = 1; u2 = 1; w = 1; end
            7'b0010011: begin u1 = 1; w = 1; end
            7'b0000011: begin u1 = 1; w = 1; ld = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; end
            7'b1100111: begin u1 = 1; w = 1; end
            7'b1101111, 7'b0110111, 7'b0010111: w = 1;
            default: ;
        endcase
    endfunction

    function automatic void lookup(input bit uses, input logic [4:0] src,
                                   output int sel, output bit lu);
        bit found = 0;
        sel = 0;
        lu  = 0;
        if (uses && src != 0) begin
            for (int i = 0; i < pipe.size(); i++) begin
                if (!found && pipe[i].v && pipe[i].wr && pipe[i].rd == src) begin
                    found = 1;
                    if (pipe[i].ld && (i + 1) <= LL) lu = 1;
                    else sel = i + 1;
                end
            end
        end
    endfunction

    function automatic void expect_now(output bit st, output bit fl, output int sa, output int sb);
        bit u1, u2, w, ld, lua, lub;
        classify(d_opcode, u1, u2, w, ld);
        lookup(u1, d_rs1, sa, lua);
        lookup(u2, d_rs2, sb, lub);
        fl = !rst && (redirect || m_fc > 0);
        st = !rst && d_valid && (lua || lub) && !fl;
        if (rst) begin
            sa = 0;
            sb = 0;
        end
    endfunction

    bit   p_st, p_fl, p_u1, p_u2, p_w, p_ld;
    int   p_sa, p_sb;
    ent_t p_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe = {};
            for (int i = 0; i < N; i++) pipe.push_back('{0, 0, 5'd0, 0});
            m_fc = 0;
            m_sc = 0;
            m_fe = 0;
        end else begin
            expect_now(p_st, p_fl, p_sa, p_sb);
            classify(d_opcode, p_u1, p_u2, p_w, p_ld);
            p_e.v  = d_valid && !p_st && !p_fl;
            p_e.wr = p_e.v && p_w && (d_rd != 0);
            p_e.rd = d_rd;
            p_e.ld = p_ld;
            pipe.push_front(p_e);
            void'(pipe.pop_back());
            if (redirect) m_fc = FC - 1;
            else if (m_fc > 0) m_fc = m_fc - 1;
            if (p_st && m_sc < CMAX) m_sc = m_sc + 1;
            if (redirect && m_fe < CMAX) m_fe = m_fe + 1;
        end
    end

    // Per-cycle compare, away from the active edge
    bit c_st, c_fl;
    int c_sa, c_sb;
    always @(negedge clk) begin
        expect_now(c_st, c_fl, c_sa, c_sb);
        check("stall", stall, c_st);
        check("flush", flush, c_fl);
        check("fwd_sel_a", fwd_sel_a, c_sa);
        check("fwd_sel_b", fwd_sel_b, c_sb);
        check("stall_count", stall_count, m_sc);
        check("flush_count", flush_count, m_fe);
    end

    // ---------------- stimulus ----------------
    task automatic put(input bit v, input logic [6:0] op, input int rs1, input int rs2,
                       input int rd, input bit redir);
        d_valid  = v;
        d_opcode = op;
        d_rs1    = 5'(rs1);
        d_rs2    = 5'(rs2);
        d_rd     = 5'(rd);
        redirect = redir;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        put(0, R, 0, 0, 0, 0);
        check("reset_stall", stall, 0);
        check("reset_flush", flush, 0);
        check("reset_stall_count", stall_count, 0);
        check("reset_flush_count", flush_count, 0);
        nxt();

        // 1: add x1,x2,x3 ; sub x4,x1,x5
        put(1, R, 2, 3, 1, 0);
        nxt();
        put(1, R, 1, 5, 4, 0);
        check("t1_sel_a", fwd_sel_a, 1);
        check("t1_sel_b", fwd_sel_b, 0);
        check("t1_stall", stall, 0);
        nxt();

        // 2: add x1 ; nop ; or x6,x7,x1
        put(1, R, 2, 3, 1, 0);
        nxt();
        put(0, R, 0, 0, 0, 0);
        nxt();
        put(1, R, 7, 1, 6, 0);
        check("t2_sel_a", fwd_sel_a, 0);
        check("t2_sel_b", fwd_sel_b, 2);
        nxt();
        // rd = x0 writer, x0 consumer
        put(1, R, 2, 3, 0, 0);
        nxt();
        put(0, R, 0, 0, 0, 0);
        nxt();
        put(1, R, 0, 0, 6, 0);
        check("t2_x0_sel_a", fwd_sel_a, 0);
        check("t2_x0_sel_b", fwd_sel_b, 0);
        nxt();

        // 3: lw x5,0(x2) ; add x6,x5,x5
        put(1, LD, 2, 0, 5, 0);
        check("t3_lw_stall", stall, 0);
        nxt();
        put(1, R, 5, 5, 6, 0);
        check("t3_stall", stall, 1);
        check("t3_stall_sel_a", fwd_sel_a, 0);
        check("t3_stall_sel_b", fwd_sel_b, 0);
        nxt();
        put(1, R, 5, 5, 6, 0);
        check("t3_after_stall", stall, 0);
        check("t3_sel_a", fwd_sel_a, 2);
        check("t3_sel_b", fwd_sel_b, 2);
        check("t3_stall_count", stall_count, 1);
        nxt();

        // 4: redirect while decode holds a load-use consumer
        put(1, LD, 2, 0, 7, 0);
        nxt();
        put(1, R, 7, 0, 8, 1);
        check("t4_flush_c1", flush, 1);
        check("t4_stall_c1", stall, 0);
        nxt();
        put(1, R, 7, 0, 8, 0);
        check("t4_flush_c2", flush, 1);
        check("t4_stall_c2", stall, 0);
        check("t4_flush_count", flush_count, 1);
        nxt();
        put(1, R, 8, 8, 9, 0);
        check("t4_flush_c3", flush, 0);
        check("t4_bubble_sel_a", fwd_sel_a, 0);
        check("t4_bubble_sel_b", fwd_sel_b, 0);
        nxt();

        // 5: two writers of x1, youngest wins
        put(1, R, 2, 3, 1, 0);
        nxt();
        put(1, R, 4, 5, 1, 0);
        nxt();
        put(1, R, 1, 1, 10, 0);
        check("t5_sel_a", fwd_sel_a, 1);
        check("t5_sel_b", fwd_sel_b, 1);
        nxt();

        // 6: preload stall_count to 13, then reset asynchronously mid-stall
        for (int i = 0; i < 12; i++) begin
            put(1, LD, 5, 0, 5, 0);
            nxt();
            put(1, R, 5, 5, 6, 0);
            nxt();
        end
        put(1, LD, 5, 0, 5, 0);
        nxt();
        put(1, R, 5, 5, 6, 0);
        check("t6_pre_stall", stall, 1);
        check("t6_pre_count", stall_count, 13);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_stall", stall, 0);
        check("t6_rst_flush", flush, 0);
        check("t6_rst_sel_a", fwd_sel_a, 0);
        check("t6_rst_sel_b", fwd_sel_b, 0);
        check("t6_rst_stall_count", stall_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 2^CNT_W + 5 forced stalls
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            put(1, LD, 5, 0, 5, 0);
            nxt();
            put(1, R, 5, 5, 6, 0);
            nxt();
        end
        put(0, R, 0, 0, 0, 0);
        check("t6_saturated", stall_count, CMAX);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the RISC-V integer pipeline; successor to the hard-coded decode-stage hazard logic in the control unit. It tracks in-flight register writers across FWD_STAGES downstream stages and generates:
- per-operand forwarding selects
- load-use stalls with configurable load latency
- multi-cycle redirect flushes
- saturating stall/flush performance counters

It sits beside the control unit at the decode boundary; the datapath consumes its selects and kill signals.

Parameters:
REG_AW, 5, register address width
FWD_STAGES, 2, number of downstream stages (X=1, M=2, ...) whose results can be forwarded; minimum 1
LOAD_LAT, 1, stage index through which a load result is not yet available; must be < FWD_STAGES
FLUSH_CYCLES, 1, cycles the decode slot is killed after a redirect; minimum 1
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
d_valid  in  1  decode slot holds a real instruction
d_opcode  in  7  decode opcode
d_rs1  in  REG_AW  source 1
d_rs2  in  REG_AW  source 2
d_rd  in  REG_AW  destination
redirect  in  1  branch taken / JAL / JALR resolved in stage 1 this cycle
stall  out  1  hold PC and decode; insert bubble into stage 1
flush  out  1  kill decode-slot instruction
fwd_sel_a  out  clog2(FWD_STAGES+1)  0 = regfile, k = stage k result
fwd_sel_b  out  clog2(FWD_STAGES+1)  same, for rs2
stall_count  out  CNT_W  cycles with stall=1, saturating
flush_count  out  CNT_W  redirect events, saturating

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high. Asserting `rst` clears all stage entries to invalid, flush_cnt to 0 and both counters to 0. While `rst`=1: stall=0, flush=0, fwd_sel_a=0, fwd_sel_b=0. Reset mid-stall or mid-flush drops those outputs immediately.
- Opcode classification (combinational, decode):
  - R 0110011: uses rs1, rs2; writes rd
  - I-ALU 0010011: uses rs1; writes rd
  - LOAD 0000011: uses rs1; writes rd; marked is_load
  - STORE 0100011: uses rs1, rs2; no write
  - BRANCH 1100011: uses rs1, rs2; no write
  - JALR 1100111: uses rs1; writes rd
  - JAL 1101111, LUI 0110111, AUIPC 0010111: no sources; write rd
  - Unknown opcode: no sources, no write
- Writer and source gating: rd=0 is never a writer. A source of x0 never matches.
- Stage tracking: entry k holds {valid, wr, rd, is_load}. Every cycle entry k+1 <= entry k, and entry FWD_STAGES is discarded. Entry 1 receives:
  - bubble (valid=0) if stall, flush or !d_valid
  - otherwise the classified decode instruction
- Forwarding, per used source: find the smallest k with entry k valid, wr, and rd==src (the youngest writer wins).
  - Match with is_load and k<=LOAD_LAT: stall=1, and that operand's select = 0.
  - Other match: select = k.
  - No match: select = 0. The regfile is write-through, so anything older than FWD_STAGES is read correctly.
- stall: OR of both operand load-use conditions, qualified by d_valid. Combinational from stage state and decode inputs; same-cycle.
- Redirect:
  - flush = redirect | (flush_cnt != 0).
  - On redirect, flush_cnt <= FLUSH_CYCLES-1. Otherwise flush_cnt decrements to 0.
  - Redirect during an active flush restarts the count.
  - Flush overrides stall: stall is forced to 0 while flush=1, and a killed instruction never stalls.
- Counters:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with redirect=1.
  - Both hold at all-ones (no wrap).
- Latency: select/stall outputs are 0-cycle (combinational). Stage state, flush_cnt and counters update at posedge clk.

Decomposition:
- Shared package `rv_pkg`: opcode localparams (OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC) and the FWD_REGFILE=0 select constant. These are shared with ALUdec and the control unit.
- Sub-module `opcode_class`: purely combinational opcode -> {uses_rs1, uses_rs2, writes_rd, is_load}.
- Everything else stays in the top module.

Test Plan:
1. Defaults, add x1,x2,x3 then sub x4,x1,x5 back-to-back -> fwd_sel_a=1, fwd_sel_b=0, stall=0.
2. add x1 ; nop ; or x6,x7,x1 -> fwd_sel_b=2 on the third instruction. The same pair with rd=x0 -> both selects 0.
3. lw x5,0(x2) then add x6,x5,x5 (LOAD_LAT=1) -> stall=1 for exactly 1 cycle with a bubble in entry 1, then fwd_sel_a=fwd_sel_b=2; stall_count=1.
4. FLUSH_CYCLES=2, redirect pulse while decode holds a load-use consumer -> flush=1 for 2 cycles, stall=0 throughout, entry 1 bubbles both cycles, flush_count=1.
5. Two writers add x1 at stages 1 and 2 with a consumer of x1 -> fwd_sel=1 (youngest wins).
6. Assert rst asynchronously mid-stall with a counter preloaded near all-ones -> stall/flush/selects go 0 before the next edge. After reset, 2^CNT_W+5 forced stalls -> stall_count saturates at all-ones.
